// File: rtl/countdown_timer_100hz_if.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer_100hz_if
//  Description : Command/status bundle between the button edge-detect logic,
//                the countdown timer and the FND controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface countdown_timer_100hz_if;
   logic        i_run_stop;
   logic        i_clear;
   logic        i_load;
   logic [13:0] i_preset;
   logic [13:0] o_count;
   logic        o_running;
   logic        o_expired;
   logic        o_done;

   // Command source: issues pulses and preset, observes the timer status.
   modport master (
      output i_run_stop, i_clear, i_load, i_preset,
      input  o_count, o_running, o_expired, o_done
   );

   // Timer side: consumes commands, drives count and status.
   modport slave (
      input  i_run_stop, i_clear, i_load, i_preset,
      output o_count, o_running, o_expired, o_done
   );
endinterface
`default_nettype wire

// File: rtl/countdown_timer_100hz.sv
`default_nettype none
// ============================================================================
//  Module      : countdown_timer_100hz
//  Description : Loadable 0-9999 countdown decremented at TICK_HZ, with an
//                internal prescaler and an IDLE/RUN/PAUSE/EXPIRED control FSM.
//  Revision    : 1.0 - initial release
// ============================================================================
module countdown_timer_100hz #(
   parameter int CLK_HZ  = 100_000_000,
   parameter int TICK_HZ = 100
) (
   input  wire                          clk,
   input  wire                          reset,
   countdown_timer_100hz_if.slave       bus
);

   localparam int          DIV         = CLK_HZ / TICK_HZ;
   localparam int          PW          = (DIV > 2) ? $clog2(DIV) : 1;
   localparam logic [13:0] c_MAX_COUNT = 14'd9999;
   localparam logic [PW-1:0] c_PRESC_TOP = PW'(DIV - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_RUN     = 2'd1,
      S_PAUSE   = 2'd2,
      S_EXPIRED = 2'd3
   } state_t;

   state_t        state_q, state_d;
   logic [13:0]   count_q, count_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          done_q,  done_d;

   logic          w_tick;
   logic [13:0]   w_preset_clamped;

   // A tick fires on the last prescaler cycle of a RUN period; the
   // decrement it causes lands on the following edge.
   assign w_tick           = (state_q == S_RUN) && (presc_q == c_PRESC_TOP);
   assign w_preset_clamped = (bus.i_preset > c_MAX_COUNT) ? c_MAX_COUNT : bus.i_preset;

   // State, count, prescaler and done registers with asynchronous reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
         count_q <= '0;
         presc_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         presc_q <= presc_d;
         done_q  <= done_d;
      end
   end

   // Next-state logic: per-state behaviour first, then clear/load override it.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      presc_d = presc_q;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            presc_d = '0;
            // A zero count has nothing to count down, so run is refused.
            if (bus.i_run_stop && (count_q != 14'd0)) begin
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            if (count_q == 14'd0) begin
               // Defensive: never decrement past zero.
               state_d = S_EXPIRED;
               presc_d = '0;
            end else begin
               presc_d = w_tick ? '0 : presc_q + 1'b1;
               if (w_tick && (count_q == 14'd1)) begin
                  // Expiry takes precedence over a simultaneous pause.
                  count_d = 14'd0;
                  state_d = S_EXPIRED;
                  done_d  = 1'b1;
                  presc_d = '0;
               end else begin
                  if (w_tick) begin
                     count_d = count_q - 14'd1;
                  end
                  if (bus.i_run_stop) begin
                     state_d = S_PAUSE;
                  end
               end
            end
         end

         S_PAUSE: begin
            // Prescaler holds so partial-tick time survives the pause.
            if (bus.i_run_stop) begin
               state_d = S_RUN;
            end
         end

         S_EXPIRED: begin
            presc_d = '0;
         end

         default: begin
            state_d = S_IDLE;
            presc_d = '0;
         end
      endcase

      if (bus.i_clear) begin
         state_d = S_IDLE;
         count_d = 14'd0;
         presc_d = '0;
         done_d  = 1'b0;
      end else if (bus.i_load && (state_q != S_RUN)) begin
         state_d = S_IDLE;
         count_d = w_preset_clamped;
         presc_d = '0;
         done_d  = 1'b0;
      end
   end

   assign bus.o_count   = count_q;
   assign bus.o_running = (state_q == S_RUN);
   assign bus.o_expired = (state_q == S_EXPIRED);
   assign bus.o_done    = done_q;

endmodule
`default_nettype wire

// File: tb/tb_countdown_timer_100hz.sv
`default_nettype none
// ============================================================================
//  Module      : tb_countdown_timer_100hz
//  Description : Self-checking bench for countdown_timer_100hz (DIV = 10):
//                directed scenarios with literal expectations plus random
//                command pulses compared every cycle against a behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_countdown_timer_100hz;

   localparam int CLK_HZ  = 1000;
   localparam int TICK_HZ = 100;
   localparam int DIV     = CLK_HZ / TICK_HZ;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   countdown_timer_100hz_if bus();

   countdown_timer_100hz #(
      .CLK_HZ  (CLK_HZ),
      .TICK_HZ (TICK_HZ)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- model
   // Model state: 0 idle, 1 run, 2 pause, 3 expired. "elapsed" is the
   // number of RUN clocks spent toward the next decrement.
   int m_state;
   int m_count;
   int m_elapsed;
   bit m_done;

   always @(posedge clk or posedge reset) begin
      int  ns, nc, ne;
      bit  nd;
      if (reset) begin
         m_state   <= 0;
         m_count   <= 0;
         m_elapsed <= 0;
         m_done    <= 1'b0;
      end else begin
         ns = m_state; nc = m_count; ne = m_elapsed; nd = 1'b0;
         if (bus.i_clear) begin
            ns = 0; nc = 0; ne = 0;
         end else if (bus.i_load && m_state != 1) begin
            ns = 0; ne = 0;
            nc = (int'(bus.i_preset) > 9999) ? 9999 : int'(bus.i_preset);
         end else if (m_state == 0) begin
            ne = 0;
            if (bus.i_run_stop && m_count != 0) ns = 1;
         end else if (m_state == 1) begin
            ne = (m_elapsed + 1) % DIV;
            if (m_elapsed + 1 == DIV) begin
               nc = m_count - 1;
               if (nc == 0) begin
                  ns = 3; nd = 1'b1;
               end else if (bus.i_run_stop) begin
                  ns = 2;
               end
            end else if (bus.i_run_stop) begin
               ns = 2;
            end
         end else if (m_state == 2) begin
            if (bus.i_run_stop) ns = 1;
         end else begin
            ne = 0;
         end
         m_state   <= ns;
         m_count   <= nc;
         m_elapsed <= ne;
         m_done    <= nd;
      end
   end

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Every cycle outside reset, the DUT must match the model.
   always @(negedge clk) begin
      if (!reset) begin
         check("model_count",   int'(bus.o_count),   m_count);
         check("model_running", int'(bus.o_running), int'(m_state == 1));
         check("model_expired", int'(bus.o_expired), int'(m_state == 3));
         check("model_done",    int'(bus.o_done),    int'(m_done));
      end
   end

   // ------------------------------------------------------------- stimulus
   // Called at a negedge: present one command for one sampling edge.
   task automatic cmd(input bit rs, input bit cl, input bit ld, input int pre);
      bus.i_run_stop = rs;
      bus.i_clear    = cl;
      bus.i_load     = ld;
      bus.i_preset   = 14'(pre);
      @(negedge clk);
      bus.i_run_stop = 1'b0;
      bus.i_clear    = 1'b0;
      bus.i_load     = 1'b0;
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      int dones;
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      bus.i_run_stop = 1'b0;
      bus.i_clear    = 1'b0;
      bus.i_load     = 1'b0;
      bus.i_preset   = 14'd0;
      wait_clk(3);
      reset = 1'b0;
      wait_clk(1);

      check("reset_count",   int'(bus.o_count),   0);
      check("reset_running", int'(bus.o_running), 0);
      check("reset_expired", int'(bus.o_expired), 0);
      check("reset_done",    int'(bus.o_done),    0);

      // Basic countdown from 3.
      cmd(0, 0, 1, 3);
      check("basic_load", int'(bus.o_count), 3);
      cmd(1, 0, 0, 0);
      check("basic_running", int'(bus.o_running), 1);
      check("model_pin_state", m_state, 1);
      wait_clk(10); check("basic_c2", int'(bus.o_count), 2);
      wait_clk(10); check("basic_c1", int'(bus.o_count), 1);
      wait_clk(9);  check("basic_pre_done", int'(bus.o_done), 0);
      check("model_pin_count", m_count, 1);
      wait_clk(1);
      check("basic_c0", int'(bus.o_count), 0);
      check("basic_done", int'(bus.o_done), 1);
      check("basic_expired", int'(bus.o_expired), 1);
      wait_clk(1);
      check("basic_done_fall", int'(bus.o_done), 0);
      check("basic_exp_hold", int'(bus.o_expired), 1);
      cmd(1, 0, 0, 0);
      check("basic_rs_ignored", int'(bus.o_running), 0);
      check("basic_rs_exp", int'(bus.o_expired), 1);

      // Clamp and zero-count guard.
      cmd(0, 0, 1, 12000);
      check("clamp", int'(bus.o_count), 9999);
      cmd(0, 1, 0, 0);
      check("clear", int'(bus.o_count), 0);
      cmd(1, 0, 0, 0);
      check("guard_running", int'(bus.o_running), 0);

      // Pause/resume keeps the partial tick.
      cmd(0, 0, 1, 5);
      cmd(1, 0, 0, 0);
      wait_clk(13);
      cmd(1, 0, 0, 0);
      check("pause_count", int'(bus.o_count), 4);
      check("pause_running", int'(bus.o_running), 0);
      check("model_pin_elapsed", m_elapsed, 4);
      wait_clk(50);
      check("pause_hold", int'(bus.o_count), 4);
      cmd(1, 0, 0, 0);
      wait_clk(5);
      check("resume_pre", int'(bus.o_count), 4);
      wait_clk(1);
      check("resume_dec", int'(bus.o_count), 3);

      // Priority cases.
      cmd(1, 0, 0, 0);
      cmd(0, 1, 1, 7);
      check("clear_over_load", int'(bus.o_count), 0);
      cmd(0, 0, 1, 5);
      cmd(1, 0, 0, 0);
      wait_clk(3);
      cmd(0, 0, 1, 7);
      check("load_in_run", int'(bus.o_count), 5);
      check("load_in_run_state", int'(bus.o_running), 1);
      wait_clk(6);
      check("load_in_run_dec", int'(bus.o_count), 4);
      cmd(0, 0, 1, 1);
      check("load_in_run2", int'(bus.o_count), 4);
      cmd(0, 1, 0, 0);
      cmd(0, 0, 1, 1);
      cmd(1, 0, 0, 0);
      wait_clk(9);
      cmd(1, 0, 0, 0);
      check("tick_rs_count", int'(bus.o_count), 0);
      check("tick_rs_expired", int'(bus.o_expired), 1);
      check("tick_rs_done", int'(bus.o_done), 1);

      // Asynchronous reset between edges while running.
      cmd(0, 0, 1, 9);
      cmd(1, 0, 0, 0);
      wait_clk(25);
      #2 reset = 1'b1;
      #1;
      check("areset_count",   int'(bus.o_count),   0);
      check("areset_running", int'(bus.o_running), 0);
      check("areset_expired", int'(bus.o_expired), 0);
      check("areset_done",    int'(bus.o_done),    0);
      #1 reset = 1'b0;
      wait_clk(1);
      cmd(0, 0, 1, 2);
      cmd(1, 0, 0, 0);
      wait_clk(20);
      check("post_reset_expired", int'(bus.o_expired), 1);
      check("post_reset_count", int'(bus.o_count), 0);

      // Reload after expiry.
      wait_clk(2);
      cmd(0, 0, 1, 4);
      check("reload_count", int'(bus.o_count), 4);
      check("reload_expired", int'(bus.o_expired), 0);
      cmd(1, 0, 0, 0);
      wait_clk(39);
      check("reload_c1", int'(bus.o_count), 1);
      dones = 0;
      for (int i = 0; i < 6; i++) begin
         wait_clk(1);
         if (bus.o_done) dones++;
      end
      check("reload_one_done", dones, 1);
      check("reload_expired_end", int'(bus.o_expired), 1);

      // Random command pulses against the model.
      for (int i = 0; i < 4000; i++) begin
         bus.i_clear    = ($urandom_range(0, 99) == 0);
         bus.i_load     = ($urandom_range(0, 19) == 0);
         bus.i_run_stop = ($urandom_range(0, 11) == 0);
         bus.i_preset   = ($urandom_range(0, 7) == 0) ? 14'($urandom_range(0, 16383))
                                                     : 14'($urandom_range(0, 6));
         @(negedge clk);
      end
      bus.i_clear    = 1'b0;
      bus.i_load     = 1'b0;
      bus.i_run_stop = 1'b0;
      wait_clk(2);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
